// File: rtl/order_ingress_arbiter.sv
// Two-requester order ingress: per-source FIFOs feeding one engine port.
// Define ARB_STRICT_PRIO_EN to give the strategy FIFO strict priority.
module order_ingress_arbiter #(
   parameter  int DEPTH = 4,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          udp_valid,
   input  logic [31:0]   udp_data,
   output logic          udp_ready,
   input  logic          strat_valid,
   input  logic [31:0]   strat_data,
   output logic          strat_ready,
   output logic          eng_valid,
   output logic [31:0]   eng_data,
   input  logic          engine_busy,
   output logic [LW-1:0] udp_level,
   output logic [LW-1:0] strat_level,
   output logic [15:0]   issued_cnt,
   output logic          last_src
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      GUARD,
      WAIT
   } state_t;

   state_t         state_q;
   logic [31:0]    mem_q [2][DEPTH];
   logic [AW-1:0]  wp_q [2];
   logic [AW-1:0]  rp_q [2];
   logic [LW-1:0]  lvl_q [2];
   logic [LW-1:0]  lvl_d [2];
   logic [1:0]     ready_q;
   logic [1:0]     in_valid;
   logic [31:0]    in_data [2];
   logic [1:0]     push;
   logic [1:0]     pop;
   logic [1:0]     nempty;
   logic           go;
   logic           sel;
   logic           eng_valid_q;
   logic [31:0]    eng_data_q;
   logic [15:0]    issued_q;
   logic           last_src_q;
`ifndef ARB_STRICT_PRIO_EN
   logic           rr_q;
`endif

   assign in_valid   = {strat_valid, udp_valid};
   assign in_data[0] = udp_data;
   assign in_data[1] = strat_data;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         push[i]  = in_valid[i] & ready_q[i];
         nempty[i] = (lvl_q[i] != '0);
      end
   end

   assign go = (state_q == IDLE) && !engine_busy && (|nempty);

   // Index 0 is UDP, index 1 is strategy.
   always_comb begin
`ifdef ARB_STRICT_PRIO_EN
      sel = nempty[1];
`else
      if (&nempty) sel = ~rr_q;
      else         sel = nempty[1];
`endif
   end

   always_comb begin
      pop = 2'b00;
      if (go) pop[sel] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         lvl_d[i] = lvl_q[i] + LW'(push[i]) - LW'(pop[i]);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) mem_q[i][wp_q[i]] <= in_data[i];
      end
   end

   // Ready is a registered look-ahead, so a full FIFO never takes a push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            wp_q[i]  <= '0;
            rp_q[i]  <= '0;
            lvl_q[i] <= '0;
         end
         ready_q <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push[i]) wp_q[i] <= wp_q[i] + 1'b1;
            if (pop[i])  rp_q[i] <= rp_q[i] + 1'b1;
            lvl_q[i]   <= lvl_d[i];
            ready_q[i] <= (lvl_d[i] < LW'(DEPTH));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         eng_valid_q <= 1'b0;
         eng_data_q  <= '0;
         issued_q    <= '0;
         last_src_q  <= 1'b0;
`ifndef ARB_STRICT_PRIO_EN
         rr_q        <= 1'b1;
`endif
      end else begin
         eng_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (go) begin
                  eng_valid_q <= 1'b1;
                  eng_data_q  <= mem_q[sel][rp_q[sel]];
                  issued_q    <= issued_q + 16'd1;
                  last_src_q  <= sel;
`ifndef ARB_STRICT_PRIO_EN
                  rr_q        <= sel;
`endif
                  state_q     <= ISSUE;
               end
            end
            ISSUE: state_q <= GUARD;
            // Engine busy is registered, so it is not yet valid here.
            GUARD: state_q <= WAIT;
            WAIT: begin
               if (!engine_busy) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign udp_ready   = ready_q[0];
   assign strat_ready = ready_q[1];
   assign udp_level   = lvl_q[0];
   assign strat_level = lvl_q[1];
   assign eng_valid   = eng_valid_q;
   assign eng_data    = eng_data_q;
   assign issued_cnt  = issued_q;
   assign last_src    = last_src_q;

endmodule
